// File: rtl/axi_burst_link_if.sv
// Port bundle of the burst link: command inputs from the bench plus the exported channel wires
// and master results. The DUT uses the slave modport; the bench drives through the master side.
interface axi_burst_link_if;
    logic         en;
    logic         en_;
    logic [15:0]  tb_R;
    logic [15:0]  tb_W;
    logic [127:0] INDATA;

    logic         ARVALID, ARREADY;
    logic         RVALID,  RREADY;
    logic         AWVALID, AWREADY;
    logic         WVALID,  WREADY;
    logic         BVALID,  BREADY;

    logic [15:0]  MOUT;
    logic [8:0]   SOUT;
    logic         RLAST;
    logic [11:0]  AWOUT;
    logic [7:0]   WDATA;
    logic         WLAST;
    logic [4:0]   BRESP;
    logic [7:0]   RDATA;
    logic         RRESP;
    logic [4:0]   BOUT;

    modport master (
        output en, en_, tb_R, tb_W, INDATA,
        input  ARVALID, ARREADY, RVALID, RREADY, AWVALID, AWREADY, WVALID, WREADY,
               BVALID, BREADY, MOUT, SOUT, RLAST, AWOUT, WDATA, WLAST, BRESP,
               RDATA, RRESP, BOUT
    );

    modport slave (
        input  en, en_, tb_R, tb_W, INDATA,
        output ARVALID, ARREADY, RVALID, RREADY, AWVALID, AWREADY, WVALID, WREADY,
               BVALID, BREADY, MOUT, SOUT, RLAST, AWOUT, WDATA, WLAST, BRESP,
               RDATA, RRESP, BOUT
    );
endinterface

// File: rtl/axi_burst_link.sv
// Burst link demonstrator: a master FSM running 1-15 beat byte bursts against a slave FSM
// backed by a 256x8 memory; every channel handshake and payload is exported for observation.
module axi_burst_link (
    input logic             clk,
    input logic             rst,
    axi_burst_link_if.slave bus
);
    typedef enum logic [2:0] {M_IDLE, M_AR, M_R, M_AW, M_W, M_B} m_state_t;
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} s_state_t;

    m_state_t     m_state;
    logic         ar_valid, r_ready, aw_valid, w_valid, w_last, b_ready;
    logic [15:0]  mout;
    logic [11:0]  awout;
    logic [7:0]   w_data;
    logic [7:0]   rdata;
    logic         rresp;
    logic [4:0]   bout;
    logic [3:0]   w_len;
    logic [3:0]   w_idx;
    logic [127:0] w_buf;

    s_state_t     s_state;
    logic         ar_ready, aw_ready, r_valid, r_last, w_ready, b_valid;
    logic [8:0]   sout;
    logic [4:0]   bresp;
    logic [7:0]   s_addr;
    logic [3:0]   s_len;
    logic [3:0]   s_id;
    logic [3:0]   s_idx;
    logic         s_err;

    logic [7:0]   mem [256];

    logic [3:0]   m_next_idx;
    logic [3:0]   s_next_idx;
    logic [7:0]   rd_addr_next;
    logic [8:0]   beat_sum;
    logic         ar_wrap;
    logic         wr_en;

    assign m_next_idx   = w_idx + 4'd1;
    assign s_next_idx   = s_idx + 4'd1;
    assign rd_addr_next = s_addr + {4'd0, s_next_idx};
    // Bit 8 of the unwrapped beat address flags a burst that has run past 0xFF.
    assign beat_sum     = {1'b0, s_addr} + {5'd0, s_idx};
    assign ar_wrap      = ({1'b0, mout[15:8]} + {5'd0, mout[7:4]}) > 9'd256;
    assign wr_en        = (s_state == S_WR) && w_valid && w_ready;

    // NOTE: every state register below uses non-blocking assignment so that both FSMs
    // see each other's pre-edge values, exactly like two separate flops on a real bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state  <= M_IDLE;
            ar_valid <= 1'b0;
            r_ready  <= 1'b0;
            aw_valid <= 1'b0;
            w_valid  <= 1'b0;
            w_last   <= 1'b0;
            b_ready  <= 1'b0;
            mout     <= '0;
            awout    <= '0;
            w_data   <= '0;
            rdata    <= '0;
            rresp    <= 1'b0;
            bout     <= '0;
            w_len    <= '0;
            w_idx    <= '0;
            w_buf    <= '0;
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (bus.en_ && bus.tb_W[7:4] != 4'd0) begin
                        w_buf    <= bus.INDATA;
                        w_len    <= bus.tb_W[7:4];
                        awout    <= {bus.tb_W[15:8], bus.tb_W[3:0]};
                        aw_valid <= 1'b1;
                        m_state  <= M_AW;
                    end else if (bus.en && bus.tb_R[7:4] != 4'd0) begin
                        mout     <= bus.tb_R;
                        ar_valid <= 1'b1;
                        rresp    <= 1'b0;
                        m_state  <= M_AR;
                    end
                end
                M_AR: begin
                    if (ar_ready) begin
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                        m_state  <= M_R;
                    end
                end
                M_R: begin
                    if (r_valid) begin
                        rdata <= sout[8:1];
                        rresp <= rresp | sout[0];
                        if (r_last) begin
                            r_ready <= 1'b0;
                            m_state <= M_IDLE;
                        end
                    end
                end
                M_AW: begin
                    if (aw_ready) begin
                        aw_valid <= 1'b0;
                        w_valid  <= 1'b1;
                        w_idx    <= 4'd0;
                        w_data   <= w_buf[7:0];
                        w_last   <= (w_len == 4'd1);
                        m_state  <= M_W;
                    end
                end
                M_W: begin
                    if (w_ready) begin
                        if (w_last) begin
                            w_valid <= 1'b0;
                            w_last  <= 1'b0;
                            b_ready <= 1'b1;
                            m_state <= M_B;
                        end else begin
                            w_idx  <= m_next_idx;
                            w_data <= w_buf[{m_next_idx, 3'b000} +: 8];
                            w_last <= (m_next_idx == w_len - 4'd1);
                        end
                    end
                end
                M_B: begin
                    if (b_valid) begin
                        b_ready <= 1'b0;
                        bout    <= bresp;
                        m_state <= M_IDLE;
                    end
                end
                default: m_state <= M_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_state  <= S_IDLE;
            ar_ready <= 1'b0;
            aw_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            sout     <= '0;
            bresp    <= '0;
            s_addr   <= '0;
            s_len    <= '0;
            s_id     <= '0;
            s_idx    <= '0;
            s_err    <= 1'b0;
        end else begin
            case (s_state)
                S_IDLE: begin
                    ar_ready <= 1'b1;
                    aw_ready <= 1'b1;
                    if (aw_valid && aw_ready) begin
                        s_addr   <= awout[11:4];
                        s_id     <= awout[3:0];
                        s_idx    <= 4'd0;
                        s_err    <= 1'b0;
                        ar_ready <= 1'b0;
                        aw_ready <= 1'b0;
                        w_ready  <= 1'b1;
                        s_state  <= S_WR;
                    end else if (ar_valid && ar_ready) begin
                        s_addr   <= mout[15:8];
                        s_len    <= mout[7:4];
                        s_id     <= mout[3:0];
                        s_idx    <= 4'd0;
                        s_err    <= ar_wrap;
                        ar_ready <= 1'b0;
                        aw_ready <= 1'b0;
                        r_valid  <= 1'b1;
                        sout     <= {mem[mout[15:8]], ar_wrap};
                        r_last   <= (mout[7:4] == 4'd1);
                        s_state  <= S_RD;
                    end
                end
                S_RD: begin
                    if (r_ready) begin
                        if (r_last) begin
                            r_valid  <= 1'b0;
                            r_last   <= 1'b0;
                            ar_ready <= 1'b1;
                            aw_ready <= 1'b1;
                            s_state  <= S_IDLE;
                        end else begin
                            s_idx  <= s_next_idx;
                            sout   <= {mem[rd_addr_next], s_err};
                            r_last <= (s_next_idx == s_len - 4'd1);
                        end
                    end
                end
                S_WR: begin
                    if (w_valid) begin
                        s_idx <= s_next_idx;
                        if (beat_sum[8])
                            s_err <= 1'b1;
                        if (w_last) begin
                            w_ready <= 1'b0;
                            b_valid <= 1'b1;
                            bresp   <= {s_id, s_err | beat_sum[8]};
                            s_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (b_ready) begin
                        b_valid  <= 1'b0;
                        ar_ready <= 1'b1;
                        aw_ready <= 1'b1;
                        s_state  <= S_IDLE;
                    end
                end
                default: s_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the memory array deliberately has no reset; its contents must survive a reset
    // pulse, and leaving it out also lets the array map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[beat_sum[7:0]] <= w_data;
    end

    assign bus.ARVALID = ar_valid;
    assign bus.ARREADY = ar_ready;
    assign bus.RVALID  = r_valid;
    assign bus.RREADY  = r_ready;
    assign bus.AWVALID = aw_valid;
    assign bus.AWREADY = aw_ready;
    assign bus.WVALID  = w_valid;
    assign bus.WREADY  = w_ready;
    assign bus.BVALID  = b_valid;
    assign bus.BREADY  = b_ready;
    assign bus.MOUT    = mout;
    assign bus.SOUT    = sout;
    assign bus.RLAST   = r_last;
    assign bus.AWOUT   = awout;
    assign bus.WDATA   = w_data;
    assign bus.WLAST   = w_last;
    assign bus.BRESP   = bresp;
    assign bus.RDATA   = rdata;
    assign bus.RRESP   = rresp;
    assign bus.BOUT    = bout;
endmodule

// File: tb/tb_axi_burst_link.sv
// Directed bench for axi_burst_link: write/read bursts, address wrap, strobe priority,
// zero-length commands and an asynchronous reset in the middle of a write burst.
module tb_axi_burst_link;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    axi_burst_link_if bus ();
    axi_burst_link dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_hs"}, 32'({bus.ARVALID, bus.ARREADY, bus.RVALID, bus.RREADY, bus.AWVALID,
                                 bus.AWREADY, bus.WVALID, bus.WREADY, bus.BVALID, bus.BREADY,
                                 bus.RLAST, bus.WLAST, bus.RRESP}), 32'd0);
        check({tag, "_ar_r"}, 32'({bus.MOUT, bus.SOUT}), 32'd0);
        check({tag, "_aw_w_b"}, 32'({bus.AWOUT, bus.WDATA, bus.BRESP}), 32'd0);
        check({tag, "_results"}, 32'({bus.RDATA, bus.BOUT}), 32'd0);
    endtask

    task automatic apply_reset(input string tag);
        bus.en  = 1'b0;
        bus.en_ = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check_zero(tag);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_write(input string tag, input logic [15:0] cmd, input logic [127:0] data,
                            input logic also_read, input logic [15:0] rd_cmd,
                            input logic [4:0] exp_bresp);
        int   beats = 0;
        logic done  = 1'b0;
        logic saw_ar = 1'b0;
        int   len   = int'(cmd[7:4]);
        bus.tb_W   = cmd;
        bus.INDATA = data;
        bus.tb_R   = rd_cmd;
        bus.en_    = 1'b1;
        bus.en     = also_read;
        @(negedge clk);
        bus.en_ = 1'b0;
        bus.en  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (bus.ARVALID)
                saw_ar = 1'b1;
            if (bus.AWVALID && bus.AWREADY)
                check({tag, "_awout"}, 32'(bus.AWOUT), 32'({cmd[15:8], cmd[3:0]}));
            if (bus.WVALID && bus.WREADY) begin
                check({tag, "_wdata"}, 32'(bus.WDATA), 32'(data[8*beats +: 8]));
                check({tag, "_wlast"}, 32'(bus.WLAST), 32'(beats == len - 1));
                beats++;
            end
            if (bus.BVALID && bus.BREADY) begin
                check({tag, "_bresp"}, 32'(bus.BRESP), 32'(exp_bresp));
                done = 1'b1;
            end
            @(negedge clk);
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_beats"}, 32'(beats), 32'(len));
        check({tag, "_bout"}, 32'(bus.BOUT), 32'(exp_bresp));
        check({tag, "_no_ar"}, 32'(saw_ar), 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [15:0] cmd, input logic [127:0] exp_data,
                           input logic exp_rresp);
        int   beats = 0;
        logic done  = 1'b0;
        logic saw_aw = 1'b0;
        int   len   = int'(cmd[7:4]);
        bus.tb_R = cmd;
        bus.en   = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (bus.AWVALID)
                saw_aw = 1'b1;
            if (bus.ARVALID && bus.ARREADY)
                check({tag, "_mout"}, 32'(bus.MOUT), 32'(cmd));
            if (bus.RVALID && bus.RREADY) begin
                check({tag, "_rbyte"}, 32'(bus.SOUT[8:1]), 32'(exp_data[8*beats +: 8]));
                check({tag, "_rlast"}, 32'(bus.RLAST), 32'(beats == len - 1));
                beats++;
                if (bus.RLAST)
                    done = 1'b1;
            end
            @(negedge clk);
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_beats"}, 32'(beats), 32'(len));
        check({tag, "_rdata"}, 32'(bus.RDATA), 32'(exp_data[8*(len-1) +: 8]));
        check({tag, "_rresp"}, 32'(bus.RRESP), 32'(exp_rresp));
        check({tag, "_no_aw"}, 32'(saw_aw), 32'd0);
    endtask

    initial begin
        logic saw;
        logic found;
        bus.en     = 1'b0;
        bus.en_    = 1'b0;
        bus.tb_R   = '0;
        bus.tb_W   = '0;
        bus.INDATA = '0;

        // 1: three-beat write to 0x01, id 1
        apply_reset("rst1");
        do_write("wr1", 16'h0131, 128'h030201, 1'b0, 16'h0000, 5'b00010);

        // 2: reset clears results but keeps memory; read the bytes back
        apply_reset("rst2");
        do_read("rd1", 16'h0131, 128'h030201, 1'b0);

        // 3: bursts crossing 0xFF wrap to 0x00 and report err
        do_write("wr_wrap", 16'hFE31, 128'hCCBBAA, 1'b0, 16'h0000, 5'b00011);
        do_read("rd_wrap", 16'hFE31, 128'hCCBBAA, 1'b1);

        // 4: simultaneous strobes take the write; LEN==0 commands are ignored
        do_write("wr_both", 16'h1022, 128'h5544, 1'b1, 16'h2013, 5'b00100);
        do_read("rd_both", 16'h1022, 128'h5544, 1'b0);
        bus.tb_R = 16'h3005;
        bus.tb_W = 16'h4006;
        bus.en   = 1'b1;
        bus.en_  = 1'b1;
        @(negedge clk);
        bus.en  = 1'b0;
        bus.en_ = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            if (bus.ARVALID || bus.AWVALID || bus.RVALID || bus.WVALID)
                saw = 1'b1;
            @(negedge clk);
        end
        check("len0_no_valid", 32'(saw), 32'd0);

        // 5: reset asserted while the third write beat is pending
        bus.tb_W   = 16'h0131;
        bus.INDATA = 128'h0C0B0A;
        bus.en_    = 1'b1;
        @(negedge clk);
        bus.en_ = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (bus.WVALID && bus.WDATA == 8'h0C)
                found = 1'b1;
            else
                @(negedge clk);
        end
        check("abort_reached_beat2", 32'(found), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_zero("abort");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        do_read("rd_abort", 16'h0131, 128'h030B0A, 1'b0);
        do_write("wr_after", 16'h5012, 128'h77, 1'b0, 16'h0000, 5'b00100);
        do_read("rd_after", 16'h5013, 128'h77, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
